// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 data mux between four requesters.
// Grants are bounded by a last flag, a beat limit, or requester withdrawal.
module mux_rr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [3:0]       last,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       select,
    output logic [3:0]       grant,
    output logic [3:0]       ack,
    output logic             busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] LIMIT = 4'(MAX_BURST - 1);

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [1:0] select_n;
    logic [3:0] grant_n;
    logic [3:0] count, count_n;

    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       accepted;
    logic       burst_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= 2'd0;
            select <= 2'd0;
            grant  <= 4'd0;
            count  <= 4'd0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            select <= select_n;
            grant  <= grant_n;
            count  <= count_n;
        end
    end

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        busy      = (state == BUSY);
        out_valid = busy & req[select];
        accepted  = out_valid & out_ready;
        ack       = accepted ? grant : 4'd0;
        out_data  = '0;
        if (busy) begin
            unique case (select)
                2'd0: out_data = in0;
                2'd1: out_data = in1;
                2'd2: out_data = in2;
                2'd3: out_data = in3;
                default: out_data = '0;
            endcase
        end
        burst_end = (busy & ~req[select])
                  | (accepted & (last[select] | (count == LIMIT)));
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        select_n = select;
        grant_n  = grant;
        count_n  = count;
        unique case (state)
            IDLE: begin
                grant_n = 4'd0;
                if (|req) begin
                    state_n  = BUSY;
                    select_n = win;
                    grant_n  = 4'b0001 << win;
                    count_n  = 4'd0;
                end
            end
            BUSY: begin
                if (burst_end) begin
                    state_n = IDLE;
                    grant_n = 4'd0;
                    count_n = 4'd0;
                    ptr_n   = select + 2'd1;
                end else if (accepted) begin
                    count_n = count + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios then random traffic,
// every cycle compared against a beat-counting reference model.
module tb_mux_rr_arbiter;

    localparam int W  = 4;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [W-1:0] din [4];
    logic [3:0]   last;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   select;
    logic [3:0]   grant;
    logic [3:0]   ack;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit m_busy;
    int m_sel;
    int m_ptr;
    int m_beats;

    mux_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .req(req),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .last(last), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data),
        .select(select), .grant(grant), .ack(ack), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance model and DUT.
    task automatic step();
        bit v;
        bit acc;
        bit fin;
        @(negedge clk);
        v   = m_busy && req[m_sel];
        acc = v && out_ready;
        check("busy", 32'(busy), 32'(m_busy));
        check("grant", 32'(grant), m_busy ? (32'd1 << m_sel) : 32'd0);
        check("select", 32'(select), 32'(m_sel));
        check("out_valid", 32'(out_valid), 32'(v));
        check("out_data", 32'(out_data), m_busy ? 32'(din[m_sel]) : 32'd0);
        check("ack", 32'(ack), acc ? (32'd1 << m_sel) : 32'd0);
        fin = 1'b0;
        if (reset) begin
            m_busy = 0; m_ptr = 0; m_sel = 0; m_beats = 0;
        end else if (!m_busy) begin
            if (req != 4'd0) begin
                for (int k = 3; k >= 0; k--)
                    if (req[(m_ptr + k) % 4]) m_sel = (m_ptr + k) % 4;
                m_busy  = 1;
                m_beats = 0;
            end
        end else if (!req[m_sel]) begin
            fin = 1'b1;
        end else if (acc) begin
            m_beats++;
            if (last[m_sel] || m_beats == MB) fin = 1'b1;
        end
        if (fin) begin
            m_busy  = 0;
            m_beats = 0;
            m_ptr   = (m_sel + 1) % 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        req       = 4'($urandom);
        last      = 4'($urandom);
        out_ready = 1'($urandom);
        for (int i = 0; i < 4; i++) din[i] = W'($urandom);
    endtask

    initial begin
        m_busy = 0; m_sel = 0; m_ptr = 0; m_beats = 0;
        // T1: reset with random inputs
        @(posedge clk);
        #1;
        reset = 1'b1;
        rand_inputs();
        @(posedge clk);
        #1;
        rand_inputs();
        step();
        rand_inputs();
        step();
        reset = 1'b0;
        req = 4'd0; last = 4'd0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = W'(i + 1);
        step();

        // T2: three-beat burst from requester 0
        req = 4'b0001; din[0] = 4'hA;
        step(); step(); step();
        last = 4'b0001;
        step();
        req = 4'd0; last = 4'd0;
        step(); step();

        // T3: everyone requesting, single-beat bursts
        req = 4'b1111; last = 4'b1111;
        repeat (10) step();
        req = 4'd0; last = 4'd0;
        step(); step();

        // T4: backpressure on requester 2
        req = 4'b0100; din[2] = 4'h5; out_ready = 1'b0;
        repeat (6) step();
        out_ready = 1'b1; last = 4'b0100;
        step();
        req = 4'd0; last = 4'd0;
        step();

        // T5: beat limit forces rotation from 0 to 1
        req = 4'b0011;
        repeat (8) step();
        req = 4'd0;
        step(); step();

        // T6: withdrawal, then reset in the middle of a burst
        req = 4'b0010; out_ready = 1'b0;
        step(); step();
        req = 4'd0;
        step(); step();
        req = 4'b1000; out_ready = 1'b1;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step(); step();

        // Random traffic
        repeat (600) begin
            rand_inputs();
            last  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            reset = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
